rip_memory_arbiter: RTL

RIP_MEMORY_ARBITER -- requirements
Module: rip_memory_arbiter

---
 rtl/rip_const.sv | 4 +
 rtl/rip_memory_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/rip_const.sv
// Shared constants for the RIP memory subsystem.
package rip_const;
  localparam int B_WIDTH = 8;
endpackage

// File: rtl/rip_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported
// memory management unit; one outstanding access at a time.
module rip_memory_arbiter
  import rip_const::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  localparam int WE_W       = DATA_WIDTH / B_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0_valid,
  input  logic [WE_W-1:0]       req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_din,
  output logic                  req0_ready,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_dout,
  input  logic                  req1_valid,
  input  logic [WE_W-1:0]       req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_din,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_dout,
  output logic [WE_W-1:0]       mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   r_prio;
  logic   w_owner_nxt;
  logic   w_prio_nxt;
  logic   w_any;
  logic   w_sel;
  logic   w_grant;
  logic   w_done;

  logic [WE_W-1:0]       w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_din;

  // Contention goes to prio; a sole requester always wins.
  always_comb begin
    w_any      = req0_valid | req1_valid;
    w_sel      = (req0_valid & req1_valid) ? r_prio
                                           : req1_valid;
    w_sel_we   = w_sel ? req1_we   : req0_we;
    w_sel_addr = w_sel ? req1_addr : req0_addr;
    w_sel_din  = w_sel ? req1_din  : req0_din;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    // Gated by rstn so every output is quiet while reset is held.
    if (rstn) begin
      unique case (r_state)
        S_IDLE: begin
          if (!mem_busy && w_any) begin
            w_grant     = 1'b1;
            w_owner_nxt = w_sel;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_busy) begin
            w_done      = 1'b1;
            w_prio_nxt  = ~r_owner;
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  assign mem_we   = w_grant ? w_sel_we : '0;
  assign mem_re   = w_grant & ~(|w_sel_we);
  assign mem_addr = w_grant ? w_sel_addr : '0;
  assign mem_din  = w_grant ? w_sel_din : '0;

  assign req0_ready = w_grant & ~w_sel;
  assign req1_ready = w_grant & w_sel;
  assign req0_done  = w_done & ~r_owner;
  assign req1_done  = w_done & r_owner;
  assign req0_dout  = req0_done ? mem_dout : '0;
  assign req1_dout  = req1_done ? mem_dout : '0;

endmodule
